imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the fetch stage (read-only, port F)
//  and the data/loader path (read/write, port D: .rodata loads, program loading).
//  One transaction in flight at a time, with round-robin arbitration.
//  Fetch responses are discarded on redirect (f_flush). A watchdog flags a memory that never responds.
// PARAMETERS
//  ADDR_WIDTH  10   word-address width of the memory (1024 words = 4KB)
//  TIMEOUT     64   cycles in WAIT without m_rvalid before abort + err
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  f_req      in   1   fetch read request; held until f_gnt
//  f_addr     in   32  fetch byte address; [1:0] ignored
//  f_flush    in   1   redirect: drop any outstanding fetch response
//  f_gnt      out  1   fetch request accepted this cycle (combinational)
//  f_rvalid   out  1   fetch data valid, 1-cycle pulse
//  f_rdata    out  32  fetch instruction word
//  d_req      in   1   data request; held until d_gnt
//  d_we       in   1   1 = write (posted), 0 = read
//  d_addr     in   32  data byte address; [1:0] ignored
//  d_wdata    in   32  write data
//  d_be       in   4   write byte enables
//  d_gnt      out  1   data request accepted this cycle (combinational)
//  d_rvalid   out  1   data read valid, 1-cycle pulse
//  d_rdata    out  32  data read word
//  m_req      out  1   memory strobe, 1 cycle, registered
//  m_we       out  1   memory write enable
//  m_addr     out  ADDR_WIDTH  word address = addr[ADDR_WIDTH+1:2]
//  m_wdata    out  32  memory write data
//  m_be       out  4   memory byte enables; 4'hF on reads
//  m_rvalid   in   1   read data returned; latency >= 1 cycle after m_req
//  m_rdata    in   32  read data
//  err        out  1   sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last_gnt=D, so F wins first contention; kill=0; timer=0.
//  FSM:
//   - IDLE: a grant is possible only here.
//   - IDLE -> ISSUE when any req is granted.
//   - ISSUE: m_* driven for exactly 1 cycle.
//   - ISSUE -> WAIT on a read.
//   - ISSUE -> IDLE on a write: posted, no response.
//   - WAIT -> IDLE the cycle after m_rvalid, or on timeout.
//  Arbitration in IDLE:
//   - only one port requesting: it wins.
//   - both requesting: the port != last_gnt wins.
//   - last_gnt updates on every grant.
//  Transfer and capture:
//   - Transfer happens when req & gnt. Owner, we, addr, wdata and be are captured that cycle.
//   - gnt is never asserted outside IDLE.
//  Read timing (grant in cycle T, memory latency L):
//   - m_req at T+1.
//   - m_rvalid at T+1+L.
//   - x_rvalid/x_rdata registered at T+2+L.
//   - Next grant possible at T+2+L.
//  Write timing: m_req at T+1; next grant possible at T+2.
//  f_flush:
//   - F owns and state is ISSUE/WAIT: set kill. The response is consumed, f_rvalid stays 0, kill clears.
//   - f_flush in the same cycle as m_rvalid: response suppressed.
//   - f_flush in IDLE, or while D owns: no effect.
//   - f_flush with f_req in IDLE: the grant is still given. The requester is responsible for the address.
//  Timeout:
//   - timer counts in WAIT and clears on leaving WAIT.
//   - timer==TIMEOUT-1 without m_rvalid: set err, go to IDLE, no rvalid pulse.
//   - A late m_rvalid arriving in IDLE or ISSUE is ignored.
//  Stray m_rvalid outside WAIT: ignored.
//  rst mid-transaction: returns to IDLE immediately; the outstanding response is discarded.
//  d_rdata/f_rdata hold their last value when rvalid is 0.
// STRUCTURE
//  defines.svh: typedef enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} imem_arb_state_t;
//  defines.svh: localparam ARB_PORT_F=1'b0, ARB_PORT_D=1'b1.
//  Single module, no sub-module: the 2-way round-robin is one flop plus a mux.
//  Timer width $clog2(TIMEOUT)+1.
// TESTING
//  1. f_req only, addr 32'h40, L=1, m_rdata=32'h00500093 ->
//     f_gnt at T, m_req at T+1 with m_addr=10'h10, f_rvalid at T+3 with f_rdata=32'h00500093.
//  2. f_req and d_req both held from reset ->
//     grants alternate F,D,F,D. Each d read returns on d_rvalid only; f_rvalid stays 0 during D ops.
//  3. d write, addr 32'h104, wdata 32'hDEADBEEF, be 4'b0011 ->
//     m_we=1, m_addr=10'h41, m_be=4'b0011. No d_rvalid. Next gnt at T+2.
//  4. F read, L=3, f_flush at T+2 ->
//     m_rvalid consumed, f_rvalid never asserts. Next F grant at T+5 returns fresh data.
//  5. D read, memory never responds, TIMEOUT=64 ->
//     err=1 after 64 WAIT cycles, FSM in IDLE. A following F read completes normally; err stays 1.
//  6. rst asserted during WAIT, then m_rvalid next cycle ->
//     no rvalid pulse on either port, all outputs 0, first post-reset contention grants F.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: state codes, port ids and the captured request
// bundle shared by the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam logic ARB_PORT_F = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } arb_req_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch port, data port and memory side of the
// instruction-memory arbiter. slave = arbiter, master = environment.
interface imem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  f_req;
  logic [31:0]           f_addr;
  logic                  f_flush;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [31:0]           f_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [31:0]           d_wdata;
  logic [3:0]            d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [31:0]           m_wdata;
  logic [3:0]            m_be;
  logic                  m_rvalid;
  logic [31:0]           m_rdata;

  logic                  err;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  m_rvalid, m_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be,
    output err
  );

  modport master (
    output f_req, f_addr, f_flush,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output m_rvalid, m_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    input  err
  );

endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of the single-port instruction
// memory between fetch (F) and data/loader (D), one access in flight.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 64
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_gnt;
  logic          owner;
  logic          we_q;
  logic          kill;
  logic [TW-1:0] timer;
  logic          idle;
  logic          f_win;
  logic          d_win;
  logic          f_drop;
  arb_req_t      sel;
  logic          unused_addr;

  assign idle  = (state == ARB_IDLE);
  assign f_win = idle & bus.f_req
               & (~bus.d_req | (last_gnt == ARB_PORT_D));
  assign d_win = idle & bus.d_req & ~f_win;

  assign bus.f_gnt = f_win;
  assign bus.d_gnt = d_win;

  assign f_drop = (owner == ARB_PORT_F) & bus.f_flush;

  always_comb begin
    sel = '{owner: ARB_PORT_F, we: 1'b0,
            addr: bus.f_addr, wdata: '0, be: 4'hF};
    unique case (1'b1)
      d_win:   sel = '{owner: ARB_PORT_D,
                       we: bus.d_we,
                       addr: bus.d_addr,
                       wdata: bus.d_wdata,
                       be: bus.d_we ? bus.d_be : 4'hF};
      f_win:   ;
      default: ;
    endcase
  end

  // Byte-offset and above-memory address bits carry no meaning here.
  assign unused_addr = ^{sel.addr[31:ADDR_WIDTH+2], sel.addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      last_gnt     <= ARB_PORT_D;
      owner        <= ARB_PORT_F;
      we_q         <= 1'b0;
      kill         <= 1'b0;
      timer        <= '0;
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.m_be     <= '0;
      bus.f_rvalid <= 1'b0;
      bus.f_rdata  <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= '0;
      bus.err      <= 1'b0;
    end else begin
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.f_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (f_win | d_win) begin
            state       <= ARB_ISSUE;
            owner       <= sel.owner;
            we_q        <= sel.we;
            last_gnt    <= sel.owner;
            bus.m_req   <= 1'b1;
            bus.m_we    <= sel.we;
            bus.m_addr  <= sel.addr[ADDR_WIDTH+1:2];
            bus.m_wdata <= sel.wdata;
            bus.m_be    <= sel.be;
          end
        end
        ARB_ISSUE: begin
          state <= we_q ? ARB_IDLE : ARB_WAIT;
          if (f_drop) kill <= 1'b1;
        end
        ARB_WAIT: begin
          timer <= timer + TW'(1);
          if (f_drop) kill <= 1'b1;
          if (bus.m_rvalid) begin
            state <= ARB_IDLE;
            timer <= '0;
            kill  <= 1'b0;
            if (owner == ARB_PORT_D) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= bus.m_rdata;
            end else if (!kill && !bus.f_flush) begin
              bus.f_rvalid <= 1'b1;
              bus.f_rdata  <= bus.m_rdata;
            end
          end else if (timer == LAST_TICK) begin
            state   <= ARB_IDLE;
            timer   <= '0;
            kill    <= 1'b0;
            bus.err <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: random F/D traffic against a memory device; a
// negedge monitor checks outputs against a queue-based reference model.
module tb_imem_arbiter;

  localparam int AW = 10;
  localparam int TO = 64;

  typedef struct {
    int          cyc;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  typedef struct {
    logic        port;
    int          t;
    int          due;
    logic [31:0] data;
    logic        silent;
    logic        killed;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  imem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  imem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at cycle %0d",
                  name, act, exp, cyc);
  endtask

  logic [31:0] dev_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  // stimulus knobs
  logic rst_hold = 1'b1;
  logic run = 1'b0;
  logic silent = 1'b0;
  logic flush_force = 1'b0;
  int   lat = 1;
  int   lat_fix = 0;
  int   f_pct = 0;
  int   d_pct = 0;
  int   flush_pct = 0;
  int   stray_pct = 0;
  int   cd = 0;
  logic [9:0] da = '0;

  // reference model state
  mreq_t mq[$];
  rsp_t  rq[$];
  int    free_at = 0;
  logic  last_m = 1'b1;
  logic  err_exp = 1'b0;
  logic [31:0] last_f = '0;
  logic [31:0] last_d = '0;

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = $urandom;
    a[11:2] = 10'($urandom_range(0, 63));
    return a;
  endfunction

  task automatic step();
    logic fg, dg;
    @(negedge clk);
    fg = bus.f_gnt;
    dg = bus.d_gnt;
    @(posedge clk);
    #1;
    rst = rst_hold;
    bus.m_rvalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = dev_mem[da];
      end
    end
    if (bus.m_req) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_be[b])
            dev_mem[bus.m_addr][8*b +: 8] = bus.m_wdata[8*b +: 8];
      end else if (!silent) begin
        cd = lat;
        da = bus.m_addr;
      end
    end
    if (!bus.m_rvalid && cd == 0 && !bus.m_req
        && $urandom_range(0, 99) < stray_pct) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = $urandom;
    end
    if (bus.f_req && fg) bus.f_req = 1'b0;
    if (bus.d_req && dg) bus.d_req = 1'b0;
    if (!bus.f_req && $urandom_range(0, 99) < f_pct) begin
      bus.f_req  = 1'b1;
      bus.f_addr = raddr();
    end
    if (!bus.d_req && $urandom_range(0, 99) < d_pct) begin
      bus.d_req   = 1'b1;
      bus.d_we    = ($urandom_range(0, 99) < 40);
      bus.d_addr  = raddr();
      bus.d_wdata = $urandom;
      bus.d_be    = 4'($urandom);
    end
    bus.f_flush = flush_force || ($urandom_range(0, 99) < flush_pct);
    lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
  endtask

  task automatic wait_drop_f();
    for (int i = 0; i < 300 && bus.f_req; i++) step();
    chk("f_grant_wait", 32'(bus.f_req), 32'd0);
  endtask

  task automatic wait_drop_d();
    for (int i = 0; i < 300 && bus.d_req; i++) step();
    chk("d_grant_wait", 32'(bus.d_req), 32'd0);
  endtask

  task automatic drain();
    f_pct = 0;
    d_pct = 0;
    for (int i = 0; i < 400 && (bus.f_req || bus.d_req
         || rq.size() > 0 || mq.size() > 0); i++) step();
    chk("drain", 32'(rq.size() + mq.size()), 32'd0);
  endtask

  // monitor / scoreboard
  rsp_t  r;
  mreq_t m;
  logic  efg, edg, efrv, edrv, em, wr, port;
  logic [31:0] addr;
  logic [9:0]  wa;
  int    due;

  always @(negedge clk) begin
    if (run) begin
      efrv = 1'b0;
      edrv = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.silent) err_exp = 1'b1;
        else if (r.port) begin
          edrv = 1'b1;
          last_d = r.data;
        end else if (!r.killed) begin
          efrv = 1'b1;
          last_f = r.data;
        end
      end
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(efrv));
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(edrv));
      chk("f_rdata", bus.f_rdata, last_f);
      chk("d_rdata", bus.d_rdata, last_d);
      chk("err", 32'(bus.err), 32'(err_exp));

      em = mq.size() > 0 && mq[0].cyc == cyc;
      chk("m_req", 32'(bus.m_req), 32'(em));
      if (em) begin
        m = mq.pop_front();
        chk("m_we", 32'(bus.m_we), 32'(m.we));
        chk("m_addr", 32'(bus.m_addr), 32'(m.addr));
        chk("m_be", 32'(bus.m_be), 32'(m.be));
        if (m.we) chk("m_wdata", bus.m_wdata, m.wdata);
      end

      if (rq.size() > 0 && !rq[0].port && bus.f_flush
          && cyc >= rq[0].t + 1 && cyc <= rq[0].due - 1)
        rq[0].killed = 1'b1;

      efg = cyc >= free_at && bus.f_req && (!bus.d_req || last_m);
      edg = cyc >= free_at && bus.d_req && !efg;
      chk("f_gnt", 32'(bus.f_gnt), 32'(efg));
      chk("d_gnt", 32'(bus.d_gnt), 32'(edg));

      if (!rst && (efg || edg)) begin
        port = edg;
        wr   = edg && bus.d_we;
        addr = edg ? bus.d_addr : bus.f_addr;
        wa   = addr[11:2];
        mq.push_back('{cyc + 1, wr, wa, bus.d_wdata,
                       wr ? bus.d_be : 4'hF});
        last_m = port;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.d_be[b])
              ref_mem[wa][8*b +: 8] = bus.d_wdata[8*b +: 8];
          free_at = cyc + 2;
        end else begin
          due = silent ? cyc + 2 + TO : cyc + 2 + lat;
          rq.push_back('{port, cyc, due, ref_mem[wa], silent, 1'b0});
          free_at = due;
        end
      end

      if (rst) begin
        rq.delete();
        mq.delete();
        free_at = cyc + 1;
        last_m  = 1'b1;
        err_exp = 1'b0;
        last_f  = '0;
        last_d  = '0;
      end
    end
  end

  initial begin
    bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_be = 0;
    bus.m_rvalid = 0; bus.m_rdata = 0;
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    @(posedge clk);
    #1;
    run = 1'b1;
    repeat (3) step();
    rst_hold = 1'b0;
    step();

    // fetch of 0x40 with latency 1
    lat_fix = 1; lat = 1;
    dev_mem[16] = 32'h00500093;
    ref_mem[16] = 32'h00500093;
    bus.f_addr = 32'h40;
    bus.f_req  = 1'b1;
    repeat (8) step();

    // posted write contending with a fetch
    bus.d_we = 1'b1; bus.d_addr = 32'h104;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
    bus.d_req = 1'b1;
    bus.f_addr = 32'h104;
    bus.f_req = 1'b1;
    repeat (10) step();

    // redirect two cycles after the fetch grant, latency 3
    lat_fix = 3; lat = 3;
    bus.f_addr = raddr();
    bus.f_req = 1'b1;
    wait_drop_f();
    flush_force = 1'b1;
    step();
    flush_force = 1'b0;
    bus.f_req = 1'b1;
    repeat (12) step();

    // random traffic, heavy contention first
    lat_fix = 0;
    flush_pct = 5;
    stray_pct = 3;
    for (int blk = 0; blk < 12; blk++) begin
      f_pct = (blk == 0) ? 100 : $urandom_range(5, 100);
      d_pct = (blk == 0) ? 100 : $urandom_range(5, 100);
      repeat (250) step();
    end
    flush_pct = 0;
    stray_pct = 0;
    drain();

    // memory that never answers a data read
    silent = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = raddr();
    bus.d_req = 1'b1;
    wait_drop_d();
    silent = 1'b0;
    repeat (70) step();
    lat_fix = 2; lat = 2;
    bus.f_addr = raddr();
    bus.f_req = 1'b1;
    repeat (10) step();
    drain();

    // reset while waiting, response lands the cycle after
    bus.f_addr = raddr();
    bus.f_req = 1'b1;
    wait_drop_f();
    step();
    rst = 1'b1;
    step();
    step();
    chk("f_rdata_rst", bus.f_rdata, 32'd0);
    chk("d_rdata_rst", bus.d_rdata, 32'd0);
    chk("err_rst", 32'(bus.err), 32'd0);
    bus.d_we = 1'b0;
    bus.d_addr = raddr();
    bus.f_addr = raddr();
    bus.f_req = 1'b1;
    bus.d_req = 1'b1;
    repeat (12) step();
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
